mul_seq: RTL and testbench
==========================

# mul_seq

Multi-cycle shift-add multiplier that replaces the single-cycle combinational multiplier in the execute stage. It is parametrised in operand width and supports both unsigned and two's-complement signed operation. Operands are captured on a start pulse, one multiplier bit is retired per clock, and a full-width product is presented with a one-cycle done pulse. The CPU's MULT/MULTU stall logic drives it and keys off `busy`/`done`.

## Interface

Parameters:
- `WIDTH`, 32, operand width in bits; must be ≥ 2. The product is `2*WIDTH` bits.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `sign_mode`  in  1  1 = signed (two's complement), 0 = unsigned; captured with `start`.
- `a`  in  WIDTH  multiplicand; captured with `start`.
- `b`  in  WIDTH  multiplier; captured with `start`.
- `busy`  out  1  high while in CALC.
- `done`  out  1  one-cycle pulse; `product` is valid in this cycle.
- `product`  out  2*WIDTH  result; held from `done` until the next `done` or reset.

## Operation

- States: IDLE, CALC, DONE. Encoding is free.
- IDLE:
  - `start`=1 captures the operands.
  - Multiplicand register x (2*WIDTH) = zero-extended |a|.
  - Multiplier register y (WIDTH) = |b|.
  - Accumulator z (2*WIDTH) = 0.
  - Negate flag = `sign_mode` & (a[WIDTH-1] ^ b[WIDTH-1]).
  - Count = 0. Next state is CALC.
- Magnitudes:
  - In unsigned mode, |v| = v.
  - In signed mode, |v| = v[WIDTH-1] ? (~v + 1) : v, taken as a WIDTH-bit unsigned value.
  - -2^(WIDTH-1) maps to 2^(WIDTH-1) with no overflow. The magnitude product is ≤ 2^(2WIDTH-2), so it fits in z.
- CALC, each cycle:
  - If y[0], then z = z + x, truncated to 2*WIDTH bits.
  - Then x <<= 1, y >>= 1, count++.
  - Exit to DONE after the cycle with count == WIDTH-1.
- DONE:
  - `product` = negate ? (~z + 1) : z.
  - `done`=1 for exactly this cycle.
  - `start` is ignored; next state is IDLE.
- `start` is ignored while in CALC or DONE. There is no queueing and no abort input.
- Operand inputs are don't-care except in the cycle where they are captured.
- Reset (`resetn`=0 at a clock edge), from any state including mid-CALC:
  - state = IDLE, `busy`=0, `done`=0, `product`=0.
  - x, y, z, count and the negate flag are cleared.
  - Any in-flight result is discarded and never reported.

## Timing

- Reset values: `busy`=0, `done`=0, `product`=0.
- A start accepted at edge t gives:
  - `busy`=1 for cycles t+1 … t+WIDTH.
  - `done`=1 in cycle t+WIDTH+1, with `busy`=0 in that cycle.
  - `product` updated at that same edge.
- Default latency is WIDTH+1 cycles from start to done.
- Earliest next accepted start is t+WIDTH+2, so throughput is one multiply per WIDTH+2 cycles.
- `busy` and `done` are never high in the same cycle.
- `start` held high continuously gives back-to-back operations at that WIDTH+2 spacing.

## Configuration

- Macro: `MUL_SEQ_EARLY_TERM_EN`.
- Defined:
  - In CALC, also exit to DONE when the post-shift y == 0.
  - Number of CALC cycles = max(1, position of the highest set bit of |b| + 1).
  - Latency = CALC cycles + 1.
  - Example: b = 0 or 1 gives `done` at t+2.
  - `product` values are identical to the undefined case.
- Undefined: latency is always WIDTH+1 regardless of the operands.

## Test plan

WIDTH=32, start accepted at edge t, macro undefined unless stated.

- Unsigned full scale: a=b=0xFFFFFFFF, sign_mode=0 → `busy` high for t+1…t+32; `done` at t+33; `product`=0xFFFFFFFE00000001.
- Signed mixed signs: a=0xFFFFFFFD (-3), b=5, sign_mode=1 → `done` at t+33; `product`=0xFFFFFFFFFFFFFFF1. Same operands with sign_mode=0 → 0x00000004FFFFFFF1.
- Signed corner: a=b=0x80000000, sign_mode=1 → `product`=0x4000000000000000. a=0x80000000, b=1 → 0xFFFFFFFF80000000.
- Start while busy: second `start` with a=2, b=2 at t+5 → ignored; first result reported at t+33; `product` unchanged until a new start in IDLE.
- Reset mid-op: `resetn`=0 at t+10 → from t+11 state is IDLE with `busy`=0, `done`=0, `product`=0. A fresh start 7×6 completes with 42 after 33 cycles.
- With `MUL_SEQ_EARLY_TERM_EN` defined:
  - a=123, b=1 → `done` at t+2, `product`=123.
  - a=3, b=0x80000000 (unsigned) → `done` at t+33, `product`=0x0000000180000000.

Source files
------------

// File: rtl/mul_seq.sv
// mul_seq: multi-cycle shift-add multiplier, unsigned or two's-complement signed.
// Operands are captured on start, one multiplier bit is retired per clock, and
// a 2*WIDTH product is presented with a one-cycle done pulse.
// Optional feature macro: MUL_SEQ_EARLY_TERM_EN. When it is defined, CALC ends
// as soon as no set multiplier bits remain. Product values do not change.
module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 sign_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [PW-1:0]    z_q, z_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [PW-1:0]    prod_q, prod_d;

  logic [PW-1:0]    sum;
  logic [WIDTH-1:0] y_shift;
  logic             last;

  // Magnitude of an operand. The most negative value maps to 2^(WIDTH-1),
  // which still fits as an unsigned WIDTH-bit value.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sm);
    return (sm && v[WIDTH-1]) ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Next-state, datapath and registered-output logic for the IDLE/CALC/DONE FSM.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    prod_d  = prod_q;
    sum     = y_q[0] ? (z_q + x_q) : z_q;
    y_shift = y_q >> 1;
`ifdef MUL_SEQ_EARLY_TERM_EN
    last    = (cnt_q == CW'(WIDTH - 1)) || (y_shift == '0);
`else
    last    = (cnt_q == CW'(WIDTH - 1));
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = {{WIDTH{1'b0}}, mag(a, sign_mode)};
          y_d     = mag(b, sign_mode);
          z_d     = '0;
          neg_d   = sign_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        z_d   = sum;
        x_d   = x_q << 1;
        y_d   = y_shift;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          // Product is loaded on the edge entering DONE so it is valid with done.
          prod_d  = neg_q ? (~sum + {{(PW-1){1'b0}}, 1'b1}) : sum;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_CALC);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: table-driven and randomized checks of mul_seq (WIDTH=32)
// against a plain-arithmetic reference model.
module tb_mul_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic          sign_mode;
  logic [W-1:0]  a, b;
  logic          busy, done;
  logic [2*W-1:0] product;

  int n_cmp  = 0;
  int n_fail = 0;

  mul_seq #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .sign_mode(sign_mode),
    .a(a), .b(b), .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   va;
    logic [W-1:0]   vb;
    logic           sm;
    logic [2*W-1:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference product from plain signed/unsigned 64-bit arithmetic.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
    longint sx, sy;
    logic [2*W-1:0] ux, uy;
    if (sm) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = {32'b0, x};
    uy = {32'b0, y};
    return ux * uy;
  endfunction

  // Expected start-to-done latency in cycles.
  function automatic int exp_lat(input logic [W-1:0] y, input logic sm);
`ifdef MUL_SEQ_EARLY_TERM_EN
    logic [W-1:0] m;
    int hb;
    m  = (sm && y[W-1]) ? (~y + 32'd1) : y;
    hb = 0;
    for (int i = 0; i < W; i++) if (m[i]) hb = i;
    return hb + 2;
`else
    return W + 1;
`endif
  endfunction

  // One operation from IDLE; optional stray start pulse sampled at edge t+inj.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ism,
                        input logic [2*W-1:0] iexp, input int ilat, input int inj, input string nm);
    int k;
    int bad;
    logic [2*W-1:0] prev;
    prev = product;
    bad  = 0;
    a = ia; b = ib; sign_mode = ism; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom;
    k = 1;
    while (k <= 100) begin
      if (inj > 1 && k == inj - 1) begin start = 1'b1; a = 2; b = 2; end
      else if (inj > 1 && k == inj) start = 1'b0;
      if (done) break;
      if (!busy || product !== prev) bad++;
      @(posedge clk); #1;
      k++;
    end
    if (busy) bad++;
    chk({nm, " latency"}, 66'(k), 66'(ilat));
    chk({nm, " product"}, {2'b0, product}, {2'b0, iexp});
    chk({nm, " busy/hold"}, 66'(bad), 66'd0);
    @(posedge clk); #1;
    chk({nm, " after done"}, {busy, done, product}, {2'b00, iexp});
  endtask

  initial begin
    vec_t tbl[11];
    int dn[$];
    int cnt;
    logic [W-1:0] ra, rb;
    logic rsm;

    tbl[0]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    tbl[1]  = '{32'hFFFF_FFFD, 32'd5,         1'b1, 64'hFFFF_FFFF_FFFF_FFF1};
    tbl[2]  = '{32'hFFFF_FFFD, 32'd5,         1'b0, 64'h0000_0004_FFFF_FFF1};
    tbl[3]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    tbl[4]  = '{32'h8000_0000, 32'd1,         1'b1, 64'hFFFF_FFFF_8000_0000};
    tbl[5]  = '{32'd123,       32'd1,         1'b0, 64'd123};
    tbl[6]  = '{32'd3,         32'h8000_0000, 1'b0, 64'h0000_0001_8000_0000};
    tbl[7]  = '{32'd0,         32'hFFFF_FFFF, 1'b1, 64'd0};
    tbl[8]  = '{32'd7,         32'd6,         1'b0, 64'd42};
    tbl[9]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1};
    tbl[10] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000};

    resetn = 1'b0; start = 1'b0; sign_mode = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset state", {busy, done, product}, 66'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Table vectors
    foreach (tbl[i])
      run_op(tbl[i].va, tbl[i].vb, tbl[i].sm, tbl[i].exp, exp_lat(tbl[i].vb, tbl[i].sm), 0,
             $sformatf("vec%0d", i));

    // Start while busy is ignored (stray start sampled at t+5)
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001,
           exp_lat(32'hFFFF_FFFF, 1'b0), 5, "start while busy");
    repeat (3) @(posedge clk);
    #1;
    chk("idle hold", {busy, done, product}, {2'b00, 64'hFFFF_FFFE_0000_0001});

    // Reset mid-operation discards the in-flight result
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; sign_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    chk("mid-op reset", {busy, done, product}, 66'd0);
    cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) cnt++;
    end
    chk("no result after reset", 66'(cnt), 66'd0);
    run_op(32'd7, 32'd6, 1'b0, 64'd42, exp_lat(32'd6, 1'b0), 0, "after reset 7x6");

    // start held high: back-to-back operations
    a = 32'h1234_5678; b = 32'h9ABC_DEF0; sign_mode = 1'b1; start = 1'b1;
    for (int c = 0; c < 400 && dn.size() < 3; c++) begin
      @(posedge clk); #1;
      if (done) begin
        dn.push_back(c);
        chk("b2b product", {2'b0, product}, {2'b0, ref_mul(32'h1234_5678, 32'h9ABC_DEF0, 1'b1)});
      end
    end
    start = 1'b0;
    chk("b2b pulses", 66'(dn.size()), 66'd3);
    if (dn.size() == 3) begin
      chk("b2b spacing 1", 66'(dn[1] - dn[0]), 66'(exp_lat(32'h9ABC_DEF0, 1'b1) + 1));
      chk("b2b spacing 2", 66'(dn[2] - dn[1]), 66'(exp_lat(32'h9ABC_DEF0, 1'b1) + 1));
    end
    @(posedge clk); #1;

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      rsm = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      run_op(ra, rb, rsm, ref_mul(ra, rb, rsm), exp_lat(rb, rsm), 0, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
